// File: rtl/nios_system_iic_pkg.sv
`default_nettype none
// ==========================================================================
// nios_system_iic_pkg : register map, bit indices and FSM encodings
// Rev 1.0
// ==========================================================================
package nios_system_iic_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CMD    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_DIV    = 2'd3;

  localparam int CMD_START = 0;
  localparam int CMD_STOP  = 1;
  localparam int CMD_WRITE = 2;
  localparam int CMD_READ  = 3;
  localparam int CMD_ACK   = 4;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_NACK = 2;
  localparam int STAT_IEN  = 3;

  localparam logic [3:0] LAST_BIT = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PH_T0 = 2'd0,
    PH_T1 = 2'd1,
    PH_T2 = 2'd2,
    PH_T3 = 2'd3
  } phase_e;

  typedef struct packed {
    logic start;
    logic stop;
    logic wr;
    logic rd;
    logic ack;
  } cmd_t;

endpackage
`default_nettype wire

// File: rtl/nios_system_iic_tick_gen.sv
`default_nettype none
// ==========================================================================
// nios_system_iic_tick_gen : quarter-SCL-period down-counter with stretch hold
// Rev 1.0
// ==========================================================================
module nios_system_iic_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             stretch_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] divm1_w;

  // A divider of zero behaves like one: a tick every cycle.
  assign divm1_w = (div_i == '0) ? '0 : div_i - DIV_W'(1);
  assign tick_o  = (cnt_q == '0) && !load_i && !stretch_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= divm1_w;
    end else if (!stretch_i) begin
      if (cnt_q == '0) cnt_q <= divm1_w;
      else             cnt_q <= cnt_q - DIV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/nios_system_iic_master.sv
`default_nettype none
// ==========================================================================
// nios_system_iic_master : Avalon-MM byte-level I2C master (START/byte/STOP)
// Rev 1.0
// ==========================================================================
module nios_system_iic_master
  import nios_system_iic_pkg::*;
#(
  parameter int CLK_DIV = 125,
  parameter int DIV_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        irq
);

  state_e           state_q, state_d;
  phase_e           ph_q, ph_d;
  logic [3:0]       bit_q, bit_d;
  logic             scl_q, scl_d, sda_q, sda_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             nack_q, nack_d, ien_q, ien_d;
  logic [7:0]       tx_q, tx_d, rx_q, rx_d;
  logic [DIV_W-1:0] div_q, div_d;
  cmd_t             cmd_q, cmd_d;
  logic             tick_w, wr_en_w, enter_w, finish_w, unused_wd;

  assign wr_en_w   = chipselect && !write_n;
  assign scl_oe    = scl_q;
  assign sda_oe    = sda_q;
  assign irq       = done_q && ien_q;
  assign unused_wd = &{1'b0, writedata};

  nios_system_iic_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .load_i    (!busy_q),
    .stretch_i (!scl_q && !scl_in),
    .div_i     (div_q),
    .tick_o    (tick_w)
  );

  always_comb begin
    state_d  = state_q;  ph_d   = ph_q;   bit_d  = bit_q;
    scl_d    = scl_q;    sda_d  = sda_q;  busy_d = busy_q;
    done_d   = done_q;   nack_d = nack_q; ien_d  = ien_q;
    tx_d     = tx_q;     rx_d   = rx_q;   div_d  = div_q;
    cmd_d    = cmd_q;
    enter_w  = 1'b0;
    finish_w = 1'b0;

    if (wr_en_w && address == ADDR_STATUS) ien_d = writedata[STAT_IEN];

    case (state_q)
      S_DONE: state_d = S_IDLE;
      S_START, S_BIT, S_STOP: begin
        if (tick_w) begin
          enter_w = 1'b1;
          if (ph_q != PH_T3) begin
            ph_d = phase_e'(ph_q + 2'd1);
            // SDA is sampled on the tick that ends the SCL-high T2 sub-step.
            if (state_q == S_BIT && ph_q == PH_T2) begin
              if (cmd_q.rd && bit_q != LAST_BIT) rx_d = {rx_q[6:0], sda_in};
              if (cmd_q.wr && bit_q == LAST_BIT) nack_d = sda_in;
            end
          end else begin
            ph_d = PH_T0;
            case (state_q)
              S_START: begin
                if (cmd_q.wr || cmd_q.rd) begin
                  state_d = S_BIT;
                  bit_d   = 4'd0;
                end else if (cmd_q.stop) begin
                  state_d = S_STOP;
                end else begin
                  finish_w = 1'b1;
                end
              end
              S_BIT: begin
                if (bit_q != LAST_BIT) begin
                  bit_d = bit_q + 4'd1;
                end else begin
                  scl_d = 1'b1;
                  sda_d = 1'b0;
                  if (cmd_q.stop) state_d = S_STOP;
                  else            finish_w = 1'b1;
                end
              end
              default: finish_w = 1'b1;
            endcase
          end
        end
      end
      default: ;
    endcase

    if (finish_w) begin
      state_d = S_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      enter_w = 1'b0;
    end

    if (!busy_q && wr_en_w) begin
      case (address)
        ADDR_DATA: tx_d  = writedata[7:0];
        ADDR_DIV:  div_d = writedata[DIV_W-1:0];
        ADDR_CMD: begin
          if (|writedata[CMD_READ:CMD_START]) begin
            cmd_d.start = writedata[CMD_START];
            cmd_d.stop  = writedata[CMD_STOP];
            cmd_d.wr    = writedata[CMD_WRITE];
            cmd_d.rd    = writedata[CMD_READ] && !writedata[CMD_WRITE];
            cmd_d.ack   = writedata[CMD_ACK];
            busy_d  = 1'b1;
            done_d  = 1'b0;
            enter_w = 1'b1;
            ph_d    = PH_T0;
            bit_d   = 4'd0;
            if (writedata[CMD_START])                            state_d = S_START;
            else if (writedata[CMD_WRITE] || writedata[CMD_READ]) state_d = S_BIT;
            else                                                  state_d = S_STOP;
          end
        end
        default: ;
      endcase
    end

    // Pad levels for the sub-step just being entered.
    if (enter_w) begin
      case (state_d)
        S_START: begin
          case (ph_d)
            PH_T0:   sda_d = 1'b0;
            PH_T1:   scl_d = 1'b0;
            PH_T2:   sda_d = 1'b1;
            default: scl_d = 1'b1;
          endcase
        end
        S_BIT: begin
          case (ph_d)
            PH_T0: begin
              scl_d = 1'b1;
              if (cmd_d.wr) sda_d = (bit_d == LAST_BIT) ? 1'b0 : !tx_q[3'd7 - bit_d[2:0]];
              else          sda_d = (bit_d == LAST_BIT) ? !cmd_d.ack : 1'b0;
              if (cmd_d.wr && bit_d == 4'd0) nack_d = 1'b0;
            end
            PH_T2:   scl_d = 1'b0;
            default: ;
          endcase
        end
        S_STOP: begin
          case (ph_d)
            PH_T0: begin
              scl_d = 1'b1;
              sda_d = 1'b1;
            end
            PH_T1:   scl_d = 1'b0;
            PH_T2:   sda_d = 1'b0;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[7:0] = rx_q;
      ADDR_STATUS: readdata[3:0] = {ien_q, nack_q, done_q, busy_q};
      ADDR_DIV:    readdata[DIV_W-1:0] = div_q;
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;  ph_q   <= PH_T0;  bit_q  <= 4'd0;
      scl_q   <= 1'b0;    sda_q  <= 1'b0;   busy_q <= 1'b0;
      done_q  <= 1'b0;    nack_q <= 1'b0;   ien_q  <= 1'b0;
      tx_q    <= 8'h00;   rx_q   <= 8'h00;  div_q  <= DIV_W'(CLK_DIV);
      cmd_q   <= '0;
    end else begin
      state_q <= state_d; ph_q   <= ph_d;   bit_q  <= bit_d;
      scl_q   <= scl_d;   sda_q  <= sda_d;  busy_q <= busy_d;
      done_q  <= done_d;  nack_q <= nack_d; ien_q  <= ien_d;
      tx_q    <= tx_d;    rx_q   <= rx_d;   div_q  <= div_d;
      cmd_q   <= cmd_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nios_system_iic_master.sv
`default_nettype none
// ==========================================================================
// tb_nios_system_iic_master : directed bench with a simple open-drain slave
// Rev 1.0
// ==========================================================================
module tb_nios_system_iic_master;
  import nios_system_iic_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata, readdata;
  logic        scl_oe, sda_oe, scl_in, sda_in, irq;

  logic        stretch_force = 1'b0;
  logic        slave_pull    = 1'b0;
  logic [8:0]  slave_bits    = '0;
  int          xfer_id = 0, seen_id = 0, stretch_bit = -1, st_left = 0;
  int          cyc = 0, rcnt = 0;
  int          rise_t [0:15];
  int          fall_t [0:15];
  logic        sda_log [0:15];
  logic        scl_p = 1'b0, sda_p = 1'b0, start_seen = 1'b0, stop_seen = 1'b0;

  int          n_checks = 0, n_errors = 0;
  logic [31:0] d;
  logic [8:0]  p;
  logic [7:0]  rdat;

  assign scl_in = !scl_oe && !stretch_force;
  assign sda_in = !sda_oe && !slave_pull;

  always #5 clk = ~clk;

  nios_system_iic_master dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_in), .sda_in(sda_in), .irq(irq)
  );

  // Slave/bus monitor: slave changes SDA after SCL falls, logs line on SCL rise.
  always @(negedge clk) begin
    cyc++;
    if (st_left > 0) begin
      st_left--;
      if (st_left == 0) stretch_force = 1'b0;
    end
    if (xfer_id != seen_id) begin
      seen_id = xfer_id; rcnt = 0; slave_pull = slave_bits[0];
      start_seen = 1'b0; stop_seen = 1'b0; st_left = 0; stretch_force = 1'b0;
    end
    if (scl_p && !scl_oe) begin
      if (rcnt < 16) begin rise_t[rcnt] = cyc; sda_log[rcnt] = sda_in; end
      if (rcnt == stretch_bit) begin stretch_force = 1'b1; st_left = 20; end
      rcnt++;
    end else if (!scl_p && scl_oe) begin
      if (rcnt >= 1 && rcnt <= 16) fall_t[rcnt-1] = cyc;
      slave_pull = (rcnt < 9) ? slave_bits[rcnt] : 1'b0;
    end
    if (!scl_p && !scl_oe) begin
      if (!sda_p && sda_oe) begin
        start_seen = 1'b1; rcnt = 0; slave_pull = slave_bits[0];
      end
      if (sda_p && !sda_oe) stop_seen = 1'b1;
    end
    scl_p = scl_oe;
    sda_p = sda_oe;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    @(posedge clk); #1;
    address = a; writedata = v; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    @(posedge clk); #1;
    address = a;
    #1 v = readdata;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      rd(ADDR_STATUS, s);
      n++;
    end while (s[STAT_BUSY] && n < 3000);
    chk(tag, {31'd0, s[STAT_BUSY]}, 32'd0);
  endtask

  task automatic launch(input logic [7:0] data, input logic [4:0] cmd, input logic [8:0] pulls);
    wr(ADDR_DATA, {24'd0, data});
    slave_bits = pulls;
    xfer_id++;
    wr(ADDR_CMD, {27'd0, cmd});
  endtask

  function automatic logic [7:0] log_byte();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = sda_log[i];
    return b;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    rd(ADDR_STATUS, d); chk("rst_status", d, 32'h0);
    rd(ADDR_DIV, d);    chk("rst_div", d, 32'd125);
    rd(ADDR_DATA, d);   chk("rst_data", d, 32'h0);
    chk("rst_pads", {30'd0, scl_oe, sda_oe}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // START + write 0x34, slave ACKs
    wr(ADDR_DIV, 32'd2);
    launch(8'h34, 5'h05, 9'h100);
    wait_idle("t1_timeout");
    chk("t1_bits", {24'd0, log_byte()}, 32'h34);
    chk("t1_period", rise_t[1] - rise_t[0], 32'd8);
    chk("t1_start", {31'd0, start_seen}, 32'd1);
    rd(ADDR_STATUS, d); chk("t1_status", d, 32'h2);
    chk("t1_pads", {30'd0, scl_oe, sda_oe}, 32'd2);

    // read + stop + NACK, slave returns 0xA5
    rdat = 8'hA5;
    for (int i = 0; i < 8; i++) p[i] = ~rdat[7-i];
    p[8] = 1'b0;
    launch(8'h00, 5'h1A, p);
    wait_idle("t2_timeout");
    rd(ADDR_DATA, d); chk("t2_rx", d, 32'hA5);
    chk("t2_line", {24'd0, log_byte()}, 32'hA5);
    chk("t2_ack_slot", {31'd0, sda_log[8]}, 32'd1);
    chk("t2_stop", {31'd0, stop_seen}, 32'd1);
    chk("t2_pads", {30'd0, scl_oe, sda_oe}, 32'd0);

    // write 0x1A unacknowledged, then repeated START with ACK
    launch(8'h1A, 5'h05, 9'h000);
    wait_idle("t3_timeout");
    rd(ADDR_STATUS, d); chk("t3_nack", d, 32'h6);
    chk("t3_bits", {24'd0, log_byte()}, 32'h1A);
    launch(8'h1A, 5'h05, 9'h100);
    wait_idle("t3b_timeout");
    rd(ADDR_STATUS, d); chk("t3_nack_clr", d, 32'h2);
    chk("t3_rstart", {31'd0, start_seen}, 32'd1);

    // clock stretch of 20 clk during T2 of bit 3
    stretch_bit = 3;
    launch(8'h5A, 5'h07, 9'h100);
    wait_idle("t4_timeout");
    stretch_bit = -1;
    chk("t4_bits", {24'd0, log_byte()}, 32'h5A);
    chk("t4_high_b2", fall_t[2] - rise_t[2], 32'd4);
    chk("t4_high_b3", fall_t[3] - rise_t[3], 32'd24);
    chk("t4_stop", {31'd0, stop_seen}, 32'd1);

    // CMD and DIV writes while busy are ignored
    launch(8'h96, 5'h05, 9'h100);
    wr(ADDR_CMD, 32'h05);
    wr(ADDR_DIV, 32'd7);
    wait_idle("t5_timeout");
    repeat (100) @(posedge clk);
    rd(ADDR_DIV, d); chk("t5_div", d, 32'd2);
    chk("t5_edges", rcnt, 32'd9);
    chk("t5_bits", {24'd0, log_byte()}, 32'h96);
    rd(ADDR_STATUS, d); chk("t5_status", d, 32'h2);

    // interrupt enable
    launch(8'hC3, 5'h06, 9'h100);
    wr(ADDR_STATUS, 32'h8);
    chk("t6_irq_busy", {31'd0, irq}, 32'd0);
    wait_idle("t6_timeout");
    chk("t6_irq_done", {31'd0, irq}, 32'd1);
    rd(ADDR_STATUS, d); chk("t6_status", d, 32'hA);
    launch(8'h81, 5'h05, 9'h100);
    chk("t6_irq_fall", {31'd0, irq}, 32'd0);

    // reset mid-byte
    repeat (30) @(posedge clk);
    rd(ADDR_STATUS, d); chk("t7_busy", {31'd0, d[STAT_BUSY]}, 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("t7_pads", {30'd0, scl_oe, sda_oe}, 32'd0);
    #1 address = ADDR_STATUS;
    #1 chk("t7_status", readdata, 32'h0);
    address = ADDR_DIV;
    #1 chk("t7_div", readdata, 32'd125);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nios_system_iic_master.md
Name: nios_system_iic_master

Overview:
- Byte-level I2C master that sequences the SCL/SDA lines of the audio-codec configuration bus, replacing software bit-banging of the clock and data PIO bits.
- Nios II writes one byte plus a command word over an Avalon-MM slave; the block generates START/repeated START, 8 data bits, ACK, and STOP with fixed quarter-period timing.
- Sits beside the existing PIOs on the system interconnect. Drives the pads through open-drain enables.

Parameters:
- CLK_DIV, 125, reset value of the quarter-SCL-period divider (50 MHz / (4 × 125) = 100 kHz).
- DIV_W, 16, width of the divider register and counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select: 0 DATA, 1 CMD, 2 STATUS, 3 DIV.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address; unused bits are 0.
- scl_oe  out  1  1 = pull SCL low; 0 = release.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- scl_in  in  1  sampled SCL pad, used for clock stretching.
- sda_in  in  1  sampled SDA pad.
- irq  out  1  equals done & ien.

Behaviour:
- Reset values: scl_oe=0, sda_oe=0, irq=0, tx/rx=0x00, busy=0, done=0, nack=0, ien=0, div=CLK_DIV, state=IDLE.
- Register map:
  - DATA[7:0]: write = tx byte; read = rx byte.
  - CMD: bit0 start, bit1 stop, bit2 write, bit3 read, bit4 ack_out (0 = ACK, 1 = NACK after a read).
  - STATUS: bit0 busy, bit1 done, bit2 nack, bit3 ien. STATUS bit3 is writable; the other bits are read-only.
  - DIV[DIV_W-1:0]: read/write.
- Writes to DATA, CMD, and DIV while busy=1 are ignored. STATUS.ien is always writable.
- CMD write when idle:
  - If no start/stop/write/read bit is set: no-op, no flag change.
  - Otherwise: busy←1 and done←0 the next cycle.
  - Phases run in order START → WRITE or READ → STOP; each phase runs only if its bit is set.
  - If write and read are both set, WRITE runs and read is ignored.
- Tick generator:
  - Counter loads div-1 at each phase entry and counts down; tick is asserted when the counter = 0.
  - div=0 is treated as 1.
  - Stretch: while scl_oe=0 and scl_in=0, the counter holds.
- Every phase step is 4 ticks, T0–T3. Each output changes on the tick that ends the previous sub-step.
- START: T0 sda_oe=0; T1 scl_oe=0; T2 sda_oe=1; T3 scl_oe=1. From a held bus (SCL low) this is a repeated START.
- Bit (9 per byte, MSB first, 9th = ACK):
  - T0: scl_oe=1; set sda_oe to the bit value. For write bits, sda_oe = ~tx[i]. For a read bit or the write-ACK slot, sda_oe=0. For the read-ACK slot, sda_oe = ~ack_out.
  - T1: hold.
  - T2: scl_oe=0.
  - T3: sda_in is sampled on the tick ending T2. The sample shifts into rx on read bits; on write, the ACK slot sample sets nack. T3 holds SCL high.
- After the 9th bit, SCL is driven low (scl_oe=1) and SDA is released.
- STOP: T0 scl_oe=1, sda_oe=1; T1 scl_oe=0; T2 sda_oe=0; T3 idle hold.
- A command ending without STOP leaves scl_oe=1 (bus held) until the next command.
- Completion: on the last tick, busy←0 and done←1 in the same cycle. nack is cleared at the START of each WRITE phase.
- Reset asserted mid-transfer: all registers return to reset values within one cycle and the pads are released. No STOP is generated.
- States: IDLE, START, BIT, STOP, DONE. DONE lasts one cycle, then returns to IDLE. A 2-bit sub-phase counter and a 4-bit bit counter (0–8) qualify the states.

Decomposition:
- Package nios_system_iic_pkg holds:
  - register address constants;
  - CMD/STATUS bit indices;
  - state enum;
  - phase enum.
- One sub-module, nios_system_iic_tick_gen: DIV_W down-counter with load, stretch-hold, and tick output.

Test Plan:
- Reset, then DIV=2, CMD=0x05 (start+write), DATA=0x34, slave ACKs:
  - Expect SCL period 8 clk.
  - SDA on the rising SCL edges reads 0,0,1,1,0,1,0,0.
  - Final state: busy=0, done=1, nack=0, scl_oe=1.
- After the previous case, CMD=0x1A (read+stop+NACK), slave drives 0xA5:
  - Expect DATA read = 0xA5.
  - 9th bit sda_oe=0.
  - STOP: SDA rises while SCL is high.
  - Final: scl_oe=0, sda_oe=0.
- Write 0x1A with slave not ACKing (sda_in=1 in the ACK slot) → nack=1. Then START+write repeated with ACK → nack=0.
- Hold scl_in=0 for 20 clk during T2 of bit 3 → the T2 duration extends by exactly 20 clk; the bit values are unchanged.
- CMD write while busy, and DIV write while busy → both ignored (DIV readback unchanged, no second transfer).
- ien=1 → irq rises the cycle done=1 and falls on the next CMD write.
- Reset pulse mid-byte → next cycle scl_oe=0, sda_oe=0, busy=0, DIV=125.
